// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store
// port: data has priority, bounded by a streak limit so a waiting fetch is served.
module mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic                  o_if_done,
   output logic [DATA_WIDTH-1:0] o_if_rdata,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [ADDR_WIDTH-1:0] i_d_addr,
   input  logic [DATA_WIDTH-1:0] i_d_wdata,
   input  logic [2:0]            i_d_addrctl,
   output logic                  o_d_done,
   output logic [DATA_WIDTH-1:0] o_d_rdata,
   output logic                  o_d_err,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [3:0]            o_mem_be,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic                  i_mem_ready,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_stall
);

   // state    | meaning
   // S_IDLE   | no access in flight; arbitrate between pending requests
   // S_BUSY_I | fetch access issued, waiting for i_mem_ready
   // S_BUSY_D | load/store access issued, waiting for i_mem_ready
   // S_DONE_I | o_if_done pulse cycle
   // S_DONE_D | o_d_done pulse cycle (also used for rejected data accesses)
   typedef enum logic [2:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_DONE_I, S_DONE_D} state_t;

   localparam int            SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   state_t                r_state, w_state_nxt;
   logic [SW-1:0]         r_streak, w_streak_nxt;
   logic                  r_mem_req, w_mem_req_nxt;
   logic                  r_mem_we, w_mem_we_nxt;
   logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [3:0]            r_mem_be, w_mem_be_nxt;
   logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic                  r_if_done, w_if_done_nxt;
   logic [DATA_WIDTH-1:0] r_if_rdata, w_if_rdata_nxt;
   logic                  r_d_done, w_d_done_nxt;
   logic                  r_d_err, w_d_err_nxt;
   logic [DATA_WIDTH-1:0] r_d_rdata, w_d_rdata_nxt;
   logic [1:0]            r_lo, w_lo_nxt;
   logic [2:0]            r_ctl, w_ctl_nxt;

   logic                  w_grant_d;
   logic                  w_d_bad;
   logic [3:0]            w_st_be;
   logic [DATA_WIDTH-1:0] w_st_data;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_ld_data;
   logic                  w_unused;

   // fetch addresses are treated as word addresses; the byte offset is dropped
   assign w_unused = ^i_if_addr[1:0];

   always_comb begin
      w_d_bad   = 1'b0;
      w_st_be   = 4'hF;
      w_st_data = i_d_wdata;
      case (i_d_addrctl)
         3'b000: begin
            w_st_be   = 4'b0001 << i_d_addr[1:0];
            w_st_data = {4{i_d_wdata[7:0]}};
         end
         3'b001: begin
            w_d_bad   = i_d_addr[0];
            w_st_be   = 4'b0011 << i_d_addr[1:0];
            w_st_data = {2{i_d_wdata[15:0]}};
         end
         3'b010:  w_d_bad = |i_d_addr[1:0];
         3'b100:  w_d_bad = i_d_we;
         3'b101:  w_d_bad = i_d_we | i_d_addr[0];
         default: w_d_bad = 1'b1;
      endcase
   end

   always_comb begin
      w_shifted = i_mem_rdata >> {r_lo, 3'b000};
      case (r_ctl)
         3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_ld_data = {24'b0, w_shifted[7:0]};
         3'b101:  w_ld_data = {16'b0, w_shifted[15:0]};
         default: w_ld_data = w_shifted;
      endcase
   end

   // fetch only overrides data once the streak has reached its limit
   assign w_grant_d = i_d_req && !(i_if_req && (r_streak == STREAK_MAX));

   always_comb begin
      w_state_nxt     = r_state;
      w_streak_nxt    = i_if_req ? r_streak : '0;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_be_nxt    = r_mem_be;
      w_mem_wdata_nxt = r_mem_wdata;
      w_lo_nxt        = r_lo;
      w_ctl_nxt       = r_ctl;
      w_if_done_nxt   = 1'b0;
      w_d_done_nxt    = 1'b0;
      w_d_err_nxt     = 1'b0;
      w_if_rdata_nxt  = r_if_rdata;
      w_d_rdata_nxt   = r_d_rdata;
      case (r_state)
         S_IDLE: begin
            if (w_grant_d) begin
               w_streak_nxt = i_if_req ? r_streak + 1'b1 : '0;
               if (w_d_bad) begin
                  w_state_nxt   = S_DONE_D;
                  w_d_done_nxt  = 1'b1;
                  w_d_err_nxt   = 1'b1;
                  w_d_rdata_nxt = '0;
               end else begin
                  w_state_nxt     = S_BUSY_D;
                  w_mem_req_nxt   = 1'b1;
                  w_mem_we_nxt    = i_d_we;
                  w_mem_addr_nxt  = {i_d_addr[ADDR_WIDTH-1:2], 2'b00};
                  w_mem_be_nxt    = i_d_we ? w_st_be : 4'hF;
                  w_mem_wdata_nxt = i_d_we ? w_st_data : '0;
                  w_lo_nxt        = i_d_addr[1:0];
                  w_ctl_nxt       = i_d_addrctl;
               end
            end else if (i_if_req) begin
               w_state_nxt     = S_BUSY_I;
               w_streak_nxt    = '0;
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_addr_nxt  = {i_if_addr[ADDR_WIDTH-1:2], 2'b00};
               w_mem_be_nxt    = 4'hF;
               w_mem_wdata_nxt = '0;
            end
         end
         S_BUSY_I: begin
            if (i_mem_ready) begin
               w_state_nxt    = S_DONE_I;
               w_mem_req_nxt  = 1'b0;
               w_if_done_nxt  = 1'b1;
               w_if_rdata_nxt = i_mem_rdata;
            end
         end
         S_BUSY_D: begin
            if (i_mem_ready) begin
               w_state_nxt   = S_DONE_D;
               w_mem_req_nxt = 1'b0;
               w_d_done_nxt  = 1'b1;
               w_d_rdata_nxt = r_mem_we ? '0 : w_ld_data;
            end
         end
         S_DONE_I, S_DONE_D: w_state_nxt = S_IDLE;
         default:            w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_streak    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'h0;
         r_mem_wdata <= '0;
         r_lo        <= 2'b00;
         r_ctl       <= 3'b000;
         r_if_done   <= 1'b0;
         r_if_rdata  <= '0;
         r_d_done    <= 1'b0;
         r_d_err     <= 1'b0;
         r_d_rdata   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_streak    <= w_streak_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_be    <= w_mem_be_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_lo        <= w_lo_nxt;
         r_ctl       <= w_ctl_nxt;
         r_if_done   <= w_if_done_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_d_done    <= w_d_done_nxt;
         r_d_err     <= w_d_err_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
      end
   end

   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;
   assign o_if_done   = r_if_done;
   assign o_if_rdata  = r_if_rdata;
   assign o_d_done    = r_d_done;
   assign o_d_err     = r_d_err;
   assign o_d_rdata   = r_d_rdata;
   assign o_stall     = (i_if_req & ~r_if_done) | (i_d_req & ~r_d_done);

endmodule
